cdb_controller: RTL and testbench
=================================

// Module: cdb_controller
// PURPOSE
//  Central owner of the common data bus (CDB). It is the grant/broadcast end of the producer
//   handshake used by execution units (cdb_out_request/_data/_tag in, cdb_out_accepted out).
//  Each cycle it picks one requesting unit round-robin, acks it combinationally, and
//   registers its result onto the broadcast CDB consumed by every reservation station.
//  Also generates the free-running arbiter_state that rotates in-unit station arbitration.
// PARAMETERS
//  DATA_WIDTH     4  bitwidth of a data word
//  CDB_TAG_WIDTH  4  bitwidth of a CDB tag (<= DATA_WIDTH)
//  PRODUCERS      2  number of execution units driving requests (>=1)
//  RS_STATE_MOD   6  modulus of rs_arbiter_state (= stations per unit)
// PORTS
//  clk               in   1                        clock, rising edge
//  rst_n             in   1                        async active-low reset
//  prod_request      in   PRODUCERS                unit i has a result pending
//  prod_data         in   PRODUCERS*DATA_WIDTH     unit i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  prod_tag          in   PRODUCERS*CDB_TAG_WIDTH  unit i tag, same packing
//  prod_accepted     out  PRODUCERS                onehot ack; unit retires its result this edge
//  cdb_valid         out  1                        broadcast valid
//  cdb_tag           out  CDB_TAG_WIDTH            broadcast tag
//  cdb_data          out  DATA_WIDTH               broadcast data
//  rs_arbiter_state  out  $clog2(RS_STATE_MOD)     rotation state fed to all units
// BEHAVIOUR
//  Reset (async, rst_n=0): cdb_valid=0, cdb_tag=0, cdb_data=0, rs_arbiter_state=0,
//   last_grant=PRODUCERS-1 (so unit 0 has top priority first). prod_accepted combinational.
//  Grant: combinational; search starts at (last_grant+1) mod PRODUCERS, first set request wins.
//   prod_accepted = grant; zero when no request. Exactly one bit set iff |prod_request.
//  Edge with grant to k: cdb_valid<=1, cdb_tag<=prod_tag[k], cdb_data<=prod_data[k],
//   last_grant<=k. Latency: ack cycle N -> broadcast visible cycle N+1, held one cycle.
//  Edge with no request: cdb_valid<=0; tag/data hold previous values; last_grant holds.
//  Back-to-back: a granted unit with another pending result may be granted next cycle only if
//   no other unit requests (strict round-robin, no unit waits > PRODUCERS-1 grants).
//  PRODUCERS==1: grant = prod_request[0]; last_grant constant 0.
//  rs_arbiter_state: +1 every cycle regardless of traffic; RS_STATE_MOD-1 wraps to 0.
//  Data/tag sampled the same edge ack is given (unit outputs are combinational, change after).
//  Tags unique across units by construction; no tag-collision checking here.
//  Reset mid-broadcast: pending broadcast dropped, cdb_valid=0 immediately (async).
//  X-safety: unselected prod_data/prod_tag never reach outputs; outputs never X after reset.
// STRUCTURE
//  Shared package cdb_pkg: DATA_WIDTH/CDB_TAG_WIDTH defaults, cdb broadcast struct/typedef
//   {valid, tag, data}, shared by execution units and this block.
//  Sub-module: round_robin_arbiter (INPUTS=PRODUCERS) reused for grant, state = last_grant+1
//   mod PRODUCERS. Rest: broadcast register, last_grant register, mod counter.
// TESTING
//  Reset: rst_n low, all requests=1 -> prod_accepted=00, cdb_valid=0, tag=0, data=0, state=0.
//  Single unit: req=01, tag0=3, data0=A, one cycle -> accepted=01; next cycle cdb_valid=1,
//   tag=3, data=A; req drops -> cdb_valid=0 following cycle, tag/data hold 3/A.
//  Contention: req=11 held 4 cycles -> accepted 01,10,01,10; broadcasts follow 1 cycle later.
//  Fairness after idle: grant unit1, idle 3 cycles, then req=11 -> unit0 granted first.
//  Counter wrap: run 13 cycles from reset -> state 0,1,2,3,4,5,0,...,0 at cycle 12.
//  Async reset mid-stream: req=11, assert rst_n mid-cycle -> cdb_valid=0 without clock edge;
//   after release, unit0 granted first.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions used by the execution units and the CDB controller.
// Default word widths, the broadcast record and an index-width helper.
package cdb_pkg;

  localparam int DEF_DATA_WIDTH    = 4;
  localparam int DEF_CDB_TAG_WIDTH = 4;

  typedef struct packed {
    logic                         valid;
    logic [DEF_CDB_TAG_WIDTH-1:0] tag;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } cdb_bus_t;

  // Width of an index into n items; never zero so single-item configurations still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_controller_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after 'start' wins.
// Produces a onehot grant, its index, and a flag that any request was granted.
module round_robin_arbiter
  import cdb_pkg::*;
#(
  parameter  int INPUTS = 2,
  localparam int IDX_W  = idx_width(INPUTS)
) (
  input  logic [INPUTS-1:0] request,
  input  logic [IDX_W-1:0]  start,
  output logic [INPUTS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  int unsigned cand_s;
  logic        hit_s;

  // Rotating priority search; each candidate is visited once so grant stays onehot.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = 0;
    hit_s       = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      cand_s        = (int'(start) + i) % INPUTS;
      hit_s         = ~grant_valid & request[cand_s];
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? IDX_W'(cand_s) : grant_idx;
      grant_valid   = grant_valid | hit_s;
    end
  end

endmodule

// File: rtl/cdb_controller.sv
// Common data bus owner: grants one producer per cycle round-robin, registers its result onto
// the broadcast bus, and runs the free-running station rotation counter.
module cdb_controller
  import cdb_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int CDB_TAG_WIDTH = DEF_CDB_TAG_WIDTH,
  parameter  int PRODUCERS     = 2,
  parameter  int RS_STATE_MOD  = 6,
  localparam int STATE_W       = idx_width(RS_STATE_MOD)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PRODUCERS-1:0]              prod_request,
  input  logic [PRODUCERS*DATA_WIDTH-1:0]   prod_data,
  input  logic [PRODUCERS*CDB_TAG_WIDTH-1:0] prod_tag,
  output logic [PRODUCERS-1:0]              prod_accepted,
  output logic                              cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic [STATE_W-1:0]                rs_arbiter_state
);

  localparam int IDX_W = idx_width(PRODUCERS);

  logic [IDX_W-1:0]         last_grant_r;
  logic [IDX_W-1:0]         start_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic [PRODUCERS-1:0]     grant_s;
  logic                     any_grant_s;
  logic [DATA_WIDTH-1:0]    sel_data_s;
  logic [CDB_TAG_WIDTH-1:0] sel_tag_s;
  logic                     cdb_valid_r;
  logic [CDB_TAG_WIDTH-1:0] cdb_tag_r;
  logic [DATA_WIDTH-1:0]    cdb_data_r;
  logic [STATE_W-1:0]       state_r;

  // Search begins one past the most recent winner.
  always_comb begin
    start_s = '0;
    if (last_grant_r == IDX_W'(PRODUCERS - 1)) begin
      start_s = '0;
    end else begin
      start_s = last_grant_r + IDX_W'(1);
    end
  end

  round_robin_arbiter #(
    .INPUTS (PRODUCERS)
  ) u_arbiter (
    .request     (prod_request),
    .start       (start_s),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (any_grant_s)
  );

  // Acknowledge is suppressed while reset is held so no unit retires a result into a dropped edge.
  always_comb begin
    prod_accepted = '0;
    if (rst_n) begin
      prod_accepted = grant_s;
    end else begin
      prod_accepted = '0;
    end
  end

  // AND-OR mux on the onehot grant: unselected (possibly X) producer lanes are masked to zero.
  always_comb begin
    sel_data_s = '0;
    sel_tag_s  = '0;
    for (int i = 0; i < PRODUCERS; i++) begin
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_s[i]}} & prod_data[i*DATA_WIDTH +: DATA_WIDTH]);
      sel_tag_s  = sel_tag_s | ({CDB_TAG_WIDTH{grant_s[i]}} & prod_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH]);
    end
  end

  // Broadcast register and round-robin history; tag/data hold when the bus goes idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_r  <= 1'b0;
      cdb_tag_r    <= '0;
      cdb_data_r   <= '0;
      last_grant_r <= IDX_W'(PRODUCERS - 1);
    end else if (any_grant_s) begin
      cdb_valid_r  <= 1'b1;
      cdb_tag_r    <= sel_tag_s;
      cdb_data_r   <= sel_data_s;
      last_grant_r <= grant_idx_s;
    end else begin
      cdb_valid_r  <= 1'b0;
    end
  end

  // Free-running station rotation counter, independent of bus traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= '0;
    end else if (state_r == STATE_W'(RS_STATE_MOD - 1)) begin
      state_r <= '0;
    end else begin
      state_r <= state_r + STATE_W'(1);
    end
  end

  assign cdb_valid        = cdb_valid_r;
  assign cdb_tag          = cdb_tag_r;
  assign cdb_data         = cdb_data_r;
  assign rs_arbiter_state = state_r;

endmodule

// File: tb/tb_cdb_controller.sv
// Self-checking bench for cdb_controller: a queue-free behavioural model checked every cycle,
// plus literal expectations for the directed scenarios, then randomized traffic with resets.
`timescale 1ns/1ns
module tb_cdb_controller;

  localparam int DW = 4;
  localparam int TW = 4;
  localparam int P  = 2;
  localparam int SM = 6;

  logic          clk;
  logic          rst_n;
  logic [P-1:0]  prod_request;
  logic [P*DW-1:0] prod_data;
  logic [P*TW-1:0] prod_tag;
  logic [P-1:0]  prod_accepted;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [2:0]    rs_arbiter_state;

  int checks;
  int failures;

  cdb_controller #(
    .DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .PRODUCERS(P), .RS_STATE_MOD(SM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prod_request(prod_request), .prod_data(prod_data),
    .prod_tag(prod_tag), .prod_accepted(prod_accepted), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rs_arbiter_state(rs_arbiter_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference state.
  int   m_last;
  bit   m_valid;
  int   m_tag;
  int   m_data;
  int   m_state;

  // Winner index by rotating priority from the unit after the last winner; -1 when idle.
  function automatic int model_winner(input logic [P-1:0] req, input int last);
    for (int i = 1; i <= P; i++) begin
      int c;
      c = (last + i) % P;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last  = P - 1;
      m_valid = 1'b0;
      m_tag   = 0;
      m_data  = 0;
      m_state = 0;
    end else begin
      int w;
      w = model_winner(prod_request, m_last);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_tag   = int'(prod_tag[w*TW +: TW]);
        m_data  = int'(prod_data[w*DW +: DW]);
        m_last  = w;
      end else begin
        m_valid = 1'b0;
      end
      m_state = (m_state + 1) % SM;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int w;
    int exp_acc;
    w = model_winner(prod_request, m_last);
    exp_acc = (rst_n && w >= 0) ? (1 << w) : 0;
    chk("model_accepted", int'(prod_accepted), exp_acc);
    chk("model_valid", int'(cdb_valid), int'(m_valid));
    chk("model_tag", int'(cdb_tag), m_tag);
    chk("model_data", int'(cdb_data), m_data);
    chk("model_state", int'(rs_arbiter_state), m_state);
  end

  task automatic set_in(input logic [1:0] r, input int t0, input int d0, input int t1, input int d1);
    prod_request = r;
    prod_tag     = {TW'(t1), TW'(t0)};
    prod_data    = {DW'(d1), DW'(d0)};
  endtask

  // Change inputs just after a rising edge, then stop at the following falling edge.
  task automatic tick(input logic [1:0] r, input int t0, input int d0, input int t1, input int d1);
    @(posedge clk);
    #1;
    set_in(r, t0, d0, t1, d1);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_in(2'b11, 7, 9, 12, 13);

    // Reset with every unit requesting.
    @(negedge clk);
    chk("rst_accepted", int'(prod_accepted), 0);
    chk("rst_valid", int'(cdb_valid), 0);
    chk("rst_tag", int'(cdb_tag), 0);
    chk("rst_data", int'(cdb_data), 0);
    chk("rst_state", int'(rs_arbiter_state), 0);
    #2;
    set_in(2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Single unit: ack now, broadcast next cycle, then idle with tag/data held.
    tick(2'b01, 3, 4'hA, 5, 1);
    chk("single_ack", int'(prod_accepted), 1);
    chk("single_state1", int'(rs_arbiter_state), 1);
    tick(2'b00, 0, 0, 0, 0);
    chk("single_bcast_valid", int'(cdb_valid), 1);
    chk("single_bcast_tag", int'(cdb_tag), 3);
    chk("single_bcast_data", int'(cdb_data), 10);
    tick(2'b00, 0, 0, 0, 0);
    chk("single_idle_valid", int'(cdb_valid), 0);
    chk("single_hold_tag", int'(cdb_tag), 3);
    chk("single_hold_data", int'(cdb_data), 10);

    // Contention after unit 0 last won: alternates starting with unit 1.
    tick(2'b11, 1, 5, 2, 6);
    chk("cont_ack0", int'(prod_accepted), 2);
    tick(2'b11, 1, 5, 2, 6);
    chk("cont_ack1", int'(prod_accepted), 1);
    chk("cont_bcast1_tag", int'(cdb_tag), 2);
    chk("cont_bcast1_data", int'(cdb_data), 6);
    tick(2'b11, 1, 5, 2, 6);
    chk("cont_ack2", int'(prod_accepted), 2);
    chk("cont_bcast2_tag", int'(cdb_tag), 1);
    chk("wrap_state_6", int'(rs_arbiter_state), 0);
    tick(2'b11, 1, 5, 2, 6);
    chk("cont_ack3", int'(prod_accepted), 1);

    // Fairness: unit 1 wins, idle three cycles, then unit 0 goes first.
    tick(2'b10, 1, 5, 2, 6);
    chk("fair_ack_u1", int'(prod_accepted), 2);
    tick(2'b00, 0, 0, 0, 0);
    tick(2'b00, 0, 0, 0, 0);
    tick(2'b00, 0, 0, 0, 0);
    tick(2'b11, 1, 5, 2, 6);
    chk("fair_ack_u0", int'(prod_accepted), 1);
    chk("wrap_state_12", int'(rs_arbiter_state), 0);
    tick(2'b00, 0, 0, 0, 0);
    chk("fair_bcast_tag", int'(cdb_tag), 1);

    // Async reset mid-stream with both units requesting.
    tick(2'b11, 1, 5, 2, 6);
    tick(2'b11, 1, 5, 2, 6);
    chk("pre_rst_valid", int'(cdb_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(cdb_valid), 0);
    chk("async_rst_accepted", int'(prod_accepted), 0);
    chk("async_rst_tag", int'(cdb_tag), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ack_u0", int'(prod_accepted), 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      tick(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 59) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rand_rst_valid", int'(cdb_valid), 0);
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
